vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Upstream raster/timing stage for the sound and graphics stages.
- Generates the pixel coordinates x and y, the sync pulses, and display_on from the pixel clock.
- Maintains the free-running frame_counter that sequences notes and envelopes downstream.
- Default timing is 640x480 at 60 Hz on a 25.175 MHz pixel clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- FC_WIDTH, 7, frame_counter width

Ports:
- clk  input  1  pixel clock
- rst  input  1  asynchronous reset, active-high
- run  input  1  1 = frame_counter advances at frame wrap; 0 = frame_counter holds (x/y keep scanning)
- x  output  10  horizontal position, 0..H_TOTAL-1
- y  output  10  vertical position, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- display_on  output  1  high inside the visible area
- line_tick  output  1  one-cycle pulse on the first pixel of each line
- frame_tick  output  1  one-cycle pulse on the first pixel of each frame
- frame_counter  output  FC_WIDTH  frames elapsed, modulo 2^FC_WIDTH

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Reset (rst high, asynchronous, takes effect immediately and overrides everything):
  - x=0, y=0, frame_counter=0
  - hsync=1, vsync=1, display_on=1
  - line_tick=0, frame_tick=0
- Reset mid-frame aborts the scan. The first rising edge after rst deasserts moves x to 1 with y=0; no tick is emitted for the aborted frame.
- All outputs are registered. hsync, vsync, display_on, line_tick and frame_tick are computed from the next-state x/y, so in every cycle they describe the x/y values presented in that same cycle (zero relative latency).
- Horizontal counter:
  - x increments by 1 every clk.
  - At x==H_TOTAL-1, x wraps to 0 and y advances.
- Vertical counter:
  - y increments on each x wrap.
  - At y==V_TOTAL-1 with x==H_TOTAL-1, y wraps to 0 (frame wrap).
- hsync = 0 iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (default 656..751).
- vsync = 0 iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (default 490..491). vsync changes only at the x wrap.
- display_on = (x < H_ACTIVE) && (y < V_ACTIVE).
- line_tick = 1 in the cycle where x==0, except the first cycle after reset release.
- frame_tick = 1 in the cycle where x==0 && y==0, except the first cycle after reset release. frame_tick implies line_tick.
- frame_counter:
  - Increments on the same edge that performs the frame wrap, if run==1 at that edge.
  - Wraps from 2^FC_WIDTH-1 to 0 with no saturation.
  - run sampled 0 at the wrap edge: frame_counter holds; frame_tick still pulses.
  - run changes at any other time: no effect.
- Width rule: x and y are 10 bits. Parameters with H_TOTAL or V_TOTAL > 1024 are illegal; elaboration fails via a static check.

Optional Feature:
- Macro: FRAME_DIV2_EN
- Defined:
  - An internal phase bit toggles at every frame wrap; it resets to 0.
  - frame_counter increments only on wraps where the phase bit was 1 (and run==1), i.e. every second frame. This halves animation and sound tempo.
  - The phase bit toggles even when run==0.
  - frame_tick is unaffected and pulses every frame.
- Undefined: frame_counter increments every frame wrap as above; no phase bit exists.

Test Plan:
- Reset release, run=1, 800 clocks:
  - x sequences 1..799 then 0; y goes 0->1.
  - hsync low exactly for x=656..751 (96 cycles).
  - display_on high for x=0..639.
  - line_tick pulses once, at x=0,y=1.
- Full frame, 420000 clocks:
  - vsync low for exactly 1600 clocks (y=490..491).
  - frame_tick pulses every 420000 clocks.
  - frame_counter reads 1 after the first wrap, 2 after the second.
- Counter wrap: run 128 frames -> frame_counter goes 127->0 on frame 128; frame_tick still pulses.
- Pause: hold run=0 across wraps 3 and 4 -> frame_counter stays 2 while frame_tick pulses twice; raise run -> next wrap gives 3.
- Async reset at x=300, y=200, between clock edges:
  - Outputs return to reset values without waiting for clk.
  - After release, next frame_tick arrives exactly 420000 clocks later.
- FRAME_DIV2_EN defined, 4 frames -> frame_counter sequence 0,0,1,1,2 at the successive wraps.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between vga_timing_gen (master) and its consumers (slave).
interface vga_timing_gen_if #(
    parameter int FC_WIDTH = 7
);
    logic                run;
    logic [9:0]          x;
    logic [9:0]          y;
    logic                hsync;
    logic                vsync;
    logic                display_on;
    logic                line_tick;
    logic                frame_tick;
    logic [FC_WIDTH-1:0] frame_counter;

    modport master (
        input  run,
        output x, y, hsync, vsync, display_on, line_tick, frame_tick, frame_counter
    );

    modport slave (
        output run,
        input  x, y, hsync, vsync, display_on, line_tick, frame_tick, frame_counter
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: x/y scan, syncs, display_on, line/frame ticks, frame_counter.
// Define FRAME_DIV2_EN to advance frame_counter only on every second frame wrap.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FC_WIDTH = 7
) (
    input  logic            clk,
    input  logic            rst,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024 (10-bit x/y)");
    end

    logic [9:0]          x_q, x_d;
    logic [9:0]          y_q, y_d;
    logic                hsync_q, hsync_d;
    logic                vsync_q, vsync_d;
    logic                disp_q, disp_d;
    logic                line_tick_q, line_tick_d;
    logic                frame_tick_q, frame_tick_d;
    logic [FC_WIDTH-1:0] fc_q, fc_d;
    logic                h_wrap;
    logic                f_wrap;
    logic                fc_inc;

`ifdef FRAME_DIV2_EN
    logic phase_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase_q <= 1'b0;
        else     phase_q <= phase_q ^ f_wrap;
    end

    always_comb fc_inc = f_wrap && bus.run && phase_q;
`else
    always_comb fc_inc = f_wrap && bus.run;
`endif

    // Decoded outputs are taken from the next-state x/y so they line up with x_q/y_q.
    always_comb begin
        h_wrap = (int'(x_q) == H_TOTAL - 1);
        f_wrap = h_wrap && (int'(y_q) == V_TOTAL - 1);
        x_d    = h_wrap ? '0 : x_q + 10'd1;
        y_d    = y_q;
        if (h_wrap) y_d = f_wrap ? '0 : y_q + 10'd1;
        hsync_d      = !((int'(x_d) >= HS_START) && (int'(x_d) < HS_END));
        vsync_d      = !((int'(y_d) >= VS_START) && (int'(y_d) < VS_END));
        disp_d       = (int'(x_d) < H_ACTIVE) && (int'(y_d) < V_ACTIVE);
        line_tick_d  = (x_d == '0);
        frame_tick_d = (x_d == '0) && (y_d == '0);
        fc_d         = fc_inc ? fc_q + {{(FC_WIDTH-1){1'b0}}, 1'b1} : fc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            disp_q       <= 1'b1;
            line_tick_q  <= 1'b0;
            frame_tick_q <= 1'b0;
            fc_q         <= '0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            disp_q       <= disp_d;
            line_tick_q  <= line_tick_d;
            frame_tick_q <= frame_tick_d;
            fc_q         <= fc_d;
        end
    end

    assign bus.x             = x_q;
    assign bus.y             = y_q;
    assign bus.hsync         = hsync_q;
    assign bus.vsync         = vsync_q;
    assign bus.display_on    = disp_q;
    assign bus.line_tick     = line_tick_q;
    assign bus.frame_tick    = frame_tick_q;
    assign bus.frame_counter = fc_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a reduced raster, checked against an elapsed-cycle model.
module tb_vga_timing_gen;
    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6, VF = 1, VS = 2, VB = 2;
    localparam int FCW = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.FC_WIDTH(FCW)) vif ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FC_WIDTH(FCW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    int n_checks = 0;
    int n_pass   = 0;
    // Model state: edges since reset release, frame wraps seen, counted increments.
    int t      = 0;
    int wraps  = 0;
    int fc_cnt = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", tag, got, exp, t, $time);
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, ".x"},     int'(vif.x), 0);
        check_val({tag, ".y"},     int'(vif.y), 0);
        check_val({tag, ".hsync"}, int'(vif.hsync), 1);
        check_val({tag, ".vsync"}, int'(vif.vsync), 1);
        check_val({tag, ".disp"},  int'(vif.display_on), 1);
        check_val({tag, ".ltick"}, int'(vif.line_tick), 0);
        check_val({tag, ".ftick"}, int'(vif.frame_tick), 0);
        check_val({tag, ".fc"},    int'(vif.frame_counter), 0);
    endtask

    task automatic check_all();
        int ex, ey;
        ex = t % HT;
        ey = (t / HT) % VT;
        check_val("x", int'(vif.x), ex);
        check_val("y", int'(vif.y), ey);
        check_val("hsync", int'(vif.hsync), (ex >= HA + HF && ex < HA + HF + HS) ? 0 : 1);
        check_val("vsync", int'(vif.vsync), (ey >= VA + VF && ey < VA + VF + VS) ? 0 : 1);
        check_val("display_on", int'(vif.display_on), (ex < HA && ey < VA) ? 1 : 0);
        check_val("line_tick", int'(vif.line_tick), (ex == 0 && t > 0) ? 1 : 0);
        check_val("frame_tick", int'(vif.frame_tick), (ex == 0 && ey == 0 && t > 0) ? 1 : 0);
        check_val("frame_counter", int'(vif.frame_counter), fc_cnt % (1 << FCW));
    endtask

    // Drive run at a negedge, let one rising edge pass, update the model, check at the next negedge.
    task automatic step(input logic r);
        bit counts;
        vif.run = r;
        @(posedge clk);
        if (t % FT == FT - 1) begin
            wraps++;
`ifdef FRAME_DIV2_EN
            counts = (wraps % 2 == 0);
`else
            counts = 1'b1;
`endif
            if (r && counts) fc_cnt++;
        end
        t++;
        @(negedge clk);
        check_all();
    endtask

    task automatic model_reset();
        t = 0;
        wraps = 0;
        fc_cnt = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int frame;
        logic r;
        vif.run = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("reset");

        rst = 1'b0;
        model_reset();
        check_all();

        // Frames 2 and 3 are paused at their wrap edges; run toggles freely mid-frame.
        for (int i = 0; i < 40 * FT; i++) begin
            frame = t / FT;
            if (t % FT == FT - 1) r = (frame == 2 || frame == 3) ? 1'b0 : 1'b1;
            else                  r = logic'($urandom_range(0, 1));
            step(r);
        end

        // Asynchronous reset landing between edges partway through a frame.
        while ((t % FT) != 4 * HT + 5) step(logic'($urandom_range(0, 1)));
        #2 rst = 1'b1;
        #1 check_reset("async");
        @(negedge clk);
        check_reset("async_hold");
        rst = 1'b0;
        model_reset();
        check_all();
        for (int i = 0; i < 3 * FT + 7; i++) begin
            r = (t % FT == FT - 1) ? 1'b1 : logic'($urandom_range(0, 1));
            step(r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
